mc_fetch_sequencer: RTL and testbench
=====================================

// Module: mc_fetch_sequencer
// PURPOSE
//  Sequencing half of the multi-cycle MIPS CPU. Holds the FSM state, PC and instruction register (IR).
//  Feeds `instruction` and `state` to the control decode LUT and consumes its PC_WE, IR_WE, PCSrc, BEN and BEQBNE.
//  Computes the next state itself; the decode LUT stays purely combinational for datapath controls.
//  Adds a memory-ready stall and a retired-instruction counter.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  CNT_W      32             width of retired-instruction counter
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   synchronous, active-high reset
//  mem_ready    in   1   memory op complete this cycle (IF fetch / MEM access)
//  mem_rdata    in   32  instruction word from memory (valid when mem_ready in IF)
//  alu_result   in   32  combinational ALU output (PC+4 during IF)
//  alu_zero     in   1   ALU zero flag
//  alu_out_reg  in   32  registered ALU output (branch target)
//  reg_a        in   32  A register (jr target)
//  PC_WE        in   1   from decode LUT
//  IR_WE        in   1   from decode LUT
//  PCSrc        in   2   from decode LUT: 0 branch target, 1 jump, 2 alu_result, 3 reg_a
//  BEN          in   1   from decode LUT: evaluate branch condition
//  BEQBNE       in   1   from decode LUT: 0 = beq, 1 = bne
//  state        out  6   current FSM state, to decode LUT
//  instruction  out  32  IR contents, to decode LUT
//  pc           out  32  program counter
//  branch_taken out  1   latched branch decision
//  retired      out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - State codes, fixed by the shared package: ID=0, IF=1, EXEC=2, MEM=3, WB=4.
//  - Reset values: state=IF, pc=RESET_PC, instruction=0, branch_taken=0, retired=0.
//  - Reset mid-instruction abandons it; no PC/IR write occurs in the reset cycle.
//  - Stall: in IF or MEM with mem_ready=0, state, pc, IR and branch_taken all hold.
//    Memory ops complete in >=1 cycle; no timeout.
//  - IF with mem_ready=1: IR<=mem_rdata if IR_WE; pc<=alu_result if PC_WE.
//  - PC load outside IF, gated by state:
//    - PCSrc=1 in ID (j) or WB (jal): pc<={pc[31:28],instruction[25:0],2'b00}.
//    - PCSrc=0 in WB with branch_taken=1: pc<=alu_out_reg.
//    - Opcode RTYPE, funct 6'b001000 (jr), in EXEC: pc<=reg_a.
//    - Otherwise PCSrc=3/2 outside IF: no PC change.
//  - Branch: BEN=1 in MEM => branch_taken<=alu_zero^BEQBNE. branch_taken clears on entry to IF.
//  - Next-state table, keyed on opcode/funct:
//    - lw: IF>ID>EXEC>MEM>WB>IF
//    - sw: IF>ID>EXEC>MEM>IF
//    - j: IF>ID>IF
//    - add/sub/slt/addi/xori/jal: IF>ID>EXEC>WB>IF
//    - jr: IF>ID>EXEC>IF
//    - beq/bne: IF>ID>EXEC>MEM>WB>IF
//    - Unknown opcode/funct, or any state code >4: next=IF. No hang; counts as retired.
//  - retired increments by 1 on every transition into IF from a non-IF state. Wraps modulo 2^CNT_W.
//  - The IF->ID transition uses the opcode of the IR being written, i.e. mem_rdata, not the stale IR.
//  - Simultaneous events:
//    - Stall has priority over every PC/IR/state write.
//    - Reset has priority over stall.
//  - All outputs are registered; the decode LUT sees the new state one cycle after the edge.
// STRUCTURE
//  - mc_pkg (shared): opcode, funct and state constants, PCSrc encodings.
//  - Sub-module mc_next_state: combinational (opcode, funct, state) -> next state, used in both this block and the bench.
//  - This block owns the registers, stall gating and PC mux.
// TESTING
//  - Reset: reset=1 two cycles -> state=1, pc=RESET_PC, IR=0, retired=0.
//  - add, mem_ready=1: four cycles IF,ID,EXEC,WB -> pc=+4, retired=1, back in IF.
//  - IF with mem_ready low 3 cycles -> state, pc and IR hold. Fetch completes on the 4th cycle.
//  - beq with alu_zero=1 in MEM, alu_out_reg=0x40 -> pc=0x40 after WB.
//    Same with bne -> pc stays at PC+4.
//  - j with instruction[25:0]=0x10, pc=0x8000_0004 -> pc=0x8000_0040 after ID, state=IF.
//  - Undefined opcode 6'b111111 -> IF>ID>IF, retired+1. Reset asserted during MEM -> state=IF next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: constants shared by the multi-cycle MIPS sequencer, its
// next-state logic and the bench.
//   - FSM state codes (fixed encoding; the decode LUT depends on it)
//   - opcode / funct constants for the supported instructions
//   - PCSrc encodings driven by the decode LUT
//   - classify(): folds opcode/funct into an instruction class
package mc_pkg;

    typedef enum logic [5:0] {
        ST_ID   = 6'd0,
        ST_IF   = 6'd1,
        ST_EXEC = 6'd2,
        ST_MEM  = 6'd3,
        ST_WB   = 6'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] PCSRC_BRANCH = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_ALU    = 2'd2;
    localparam logic [1:0] PCSRC_REG_A  = 2'd3;

    // Instruction classes sharing one path through the FSM.
    typedef enum logic [2:0] {
        CL_BAD, CL_LW, CL_SW, CL_J, CL_ALU, CL_JR, CL_BR
    } iclass_e;

    function automatic iclass_e classify(input logic [5:0] opcode,
                                         input logic [5:0] funct);
        iclass_e cls;
        cls = CL_BAD;
        case (opcode)
            OP_LW:                    cls = CL_LW;
            OP_SW:                    cls = CL_SW;
            OP_J:                     cls = CL_J;
            OP_BEQ, OP_BNE:           cls = CL_BR;
            OP_ADDI, OP_XORI, OP_JAL: cls = CL_ALU;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_SLT: cls = CL_ALU;
                    FN_JR:                  cls = CL_JR;
                    default:                cls = CL_BAD;
                endcase
            end
            default:                  cls = CL_BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// mc_next_state: purely combinational next-state function of the
// multi-cycle FSM.
//   opcode     in  6  opcode of the instruction being sequenced
//   funct      in  6  funct field (only meaningful for R-type)
//   state      in  6  current state code (any 6-bit value accepted)
//   next_state out    state to enter on the next un-stalled edge
// Unknown instructions leave ID straight back to IF, and any state code
// outside the defined set recovers to IF, so the FSM can never hang.
module mc_next_state
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [5:0] state,
    output state_e     next_state
);

    iclass_e cls;

    always_comb begin
        cls        = classify(opcode, funct);
        next_state = ST_IF;
        case (state)
            ST_IF: next_state = ST_ID;
            ST_ID: begin
                if (cls == CL_BAD || cls == CL_J) next_state = ST_IF;
                else                              next_state = ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CL_LW, CL_SW, CL_BR: next_state = ST_MEM;
                    CL_ALU:              next_state = ST_WB;
                    default:             next_state = ST_IF;
                endcase
            end
            ST_MEM: begin
                case (cls)
                    CL_LW, CL_BR: next_state = ST_WB;
                    default:      next_state = ST_IF;
                endcase
            end
            default: next_state = ST_IF;
        endcase
    end

endmodule

// File: rtl/mc_fetch_sequencer.sv
// mc_fetch_sequencer: sequencing half of the multi-cycle MIPS CPU.
// Owns the FSM state, PC, IR, latched branch decision and the
// retired-instruction counter.
//   clk, reset    clock; synchronous active-high reset
//   mem_ready     memory op done this cycle (IF fetch / MEM access)
//   mem_rdata     fetched instruction word
//   alu_result    combinational ALU output (PC+4 during IF)
//   alu_zero      ALU zero flag
//   alu_out_reg   registered ALU output (branch target)
//   reg_a         A register (jr target)
//   PC_WE, IR_WE, PCSrc, BEN, BEQBNE   controls from the decode LUT
//   state         current FSM state code (to decode LUT, also debug)
//   instruction   IR contents (to decode LUT)
//   pc            program counter
//   branch_taken  branch decision latched in MEM
//   retired       completed-instruction count, wraps
// Memory handshake: in IF and MEM the current operation is outstanding
// until a cycle with mem_ready=1; that cycle's edge completes it. While
// mem_ready=0 in those states every register holds. mem_ready is
// ignored in all other states. Reset overrides the stall.
module mc_fetch_sequencer
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic [31:0]      alu_out_reg,
    input  logic [31:0]      reg_a,
    input  logic             PC_WE,
    input  logic             IR_WE,
    input  logic [1:0]       PCSrc,
    input  logic             BEN,
    input  logic             BEQBNE,
    output logic [5:0]       state,
    output logic [31:0]      instruction,
    output logic [31:0]      pc,
    output logic             branch_taken,
    output logic [CNT_W-1:0] retired
);

    state_e      state_q;
    state_e      next_state;
    logic [5:0]  dec_opcode;
    logic [5:0]  dec_funct;
    logic        stall;
    logic        enter_if;
    logic        is_jr;
    logic [31:0] jump_target;

    assign state = state_q;

    // In IF the IR is still stale; decode the word being fetched instead.
    assign dec_opcode = (state_q == ST_IF) ? mem_rdata[31:26] : instruction[31:26];
    assign dec_funct  = (state_q == ST_IF) ? mem_rdata[5:0]   : instruction[5:0];

    mc_next_state u_next_state (
        .opcode     (dec_opcode),
        .funct      (dec_funct),
        .state      (state_q),
        .next_state (next_state)
    );

    assign stall       = ((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready;
    assign enter_if    = (next_state == ST_IF) && (state_q != ST_IF);
    assign is_jr       = (instruction[31:26] == OP_RTYPE) && (instruction[5:0] == FN_JR);
    assign jump_target = {pc[31:28], instruction[25:0], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IF;
            pc           <= RESET_PC;
            instruction  <= 32'h0;
            branch_taken <= 1'b0;
            retired      <= '0;
        end else if (!stall) begin
            state_q <= next_state;

            if (enter_if)
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};

            // WB still sees the old decision on the edge that returns to IF.
            if (state_q == ST_MEM && BEN)
                branch_taken <= alu_zero ^ BEQBNE;
            else if (enter_if)
                branch_taken <= 1'b0;

            // PC sources outside IF are selected by state, not by PC_WE.
            case (state_q)
                ST_IF: begin
                    if (IR_WE) instruction <= mem_rdata;
                    if (PC_WE) pc          <= alu_result;
                end
                ST_ID: begin
                    if (PCSrc == PCSRC_JUMP) pc <= jump_target;
                end
                ST_EXEC: begin
                    if (is_jr) pc <= reg_a;
                end
                ST_WB: begin
                    if (PCSrc == PCSRC_JUMP)
                        pc <= jump_target;
                    else if (PCSrc == PCSRC_BRANCH && branch_taken)
                        pc <= alu_out_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_fetch_sequencer.sv
module tb_mc_fetch_sequencer;
    import mc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] alu_result = '0;
    logic        alu_zero = 1'b0;
    logic [31:0] alu_out_reg = '0;
    logic [31:0] reg_a = '0;
    logic        PC_WE = 1'b0;
    logic        IR_WE = 1'b0;
    logic [1:0]  PCSrc = 2'd2;
    logic        BEN = 1'b0;
    logic        BEQBNE = 1'b0;
    logic [5:0]  state;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        branch_taken;
    logic [31:0] retired;

    mc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_out_reg(alu_out_reg),
        .reg_a(reg_a), .PC_WE(PC_WE), .IR_WE(IR_WE), .PCSrc(PCSrc), .BEN(BEN),
        .BEQBNE(BEQBNE), .state(state), .instruction(instruction), .pc(pc),
        .branch_taken(branch_taken), .retired(retired)
    );

    // Stand-alone next-state instance for state codes the top cannot reach.
    logic [5:0] ns_opcode = '0;
    logic [5:0] ns_funct = '0;
    logic [5:0] ns_state = '0;
    state_e     ns_next;

    mc_next_state u_ns (
        .opcode(ns_opcode), .funct(ns_funct), .state(ns_state), .next_state(ns_next)
    );

    // ---------------- instruction words ----------------
    localparam logic [31:0] I_ADD  = 32'h0022_1820;  // add $3,$1,$2
    localparam logic [31:0] I_BEQ  = 32'h1022_0004;
    localparam logic [31:0] I_BNE  = 32'h1422_0004;
    localparam logic [31:0] I_LW   = 32'h8C22_0000;
    localparam logic [31:0] I_SW   = 32'hAC22_0000;
    localparam logic [31:0] I_JR   = 32'h00A0_0008;  // jr $5
    localparam logic [31:0] I_JAL  = 32'h0C00_0020;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;  // opcode 6'b111111
    localparam logic [31:0] I_BADF = 32'h0000_003F;  // R-type, unknown funct

    // ---------------- vector records ----------------
    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] aor;
        logic [31:0] rega;
        logic        pcwe;
        logic        irwe;
        logic [1:0]  src;
        logic        ben;
        logic        bne;
        logic [5:0]  e_state;
        logic [31:0] e_ir;
        logic [31:0] e_pc;
        logic        e_bt;
        logic [31:0] e_ret;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] rst, input logic [31:0] rdy, input logic [31:0] rdata,
        input logic [31:0] alu, input logic [31:0] zero, input logic [31:0] aor,
        input logic [31:0] rega, input logic [31:0] pcwe, input logic [31:0] irwe,
        input logic [31:0] src, input logic [31:0] ben, input logic [31:0] bne,
        input logic [5:0] est, input logic [31:0] eir, input logic [31:0] epc,
        input logic [31:0] ebt, input logic [31:0] eret);
        vec_t v;
        v.rst = rst[0];   v.rdy = rdy[0];   v.rdata = rdata; v.alu = alu;
        v.zero = zero[0]; v.aor = aor;      v.rega = rega;   v.pcwe = pcwe[0];
        v.irwe = irwe[0]; v.src = src[1:0]; v.ben = ben[0];  v.bne = bne[0];
        v.e_state = est;  v.e_ir = eir;     v.e_pc = epc;    v.e_bt = ebt[0];
        v.e_ret = eret;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int step  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, check 1 ns after the rising edge.
    task automatic cyc(input vec_t v);
        @(negedge clk);
        reset = v.rst;   mem_ready = v.rdy; mem_rdata = v.rdata; alu_result = v.alu;
        alu_zero = v.zero; alu_out_reg = v.aor; reg_a = v.rega; PC_WE = v.pcwe;
        IR_WE = v.irwe;  PCSrc = v.src;     BEN = v.ben;         BEQBNE = v.bne;
        @(posedge clk);
        #1;
        chk("state",        32'(state),        32'(v.e_state));
        chk("instruction",  instruction,       v.e_ir);
        chk("pc",           pc,                v.e_pc);
        chk("branch_taken", 32'(branch_taken), 32'(v.e_bt));
        chk("retired",      retired,           v.e_ret);
        step++;
    endtask

    vec_t tbl[$];

    initial begin
        //              rst rdy rdata   alu           z aor     rega          we ir src ben bne | state   ir      pc            bt ret
        // reset, including a reset cycle with write enables active
        tbl.push_back(mk(1, 0, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_IF,   0,      0,            0, 0));
        tbl.push_back(mk(1, 1, I_ADD,  32'h4,        0, 0,     0,            1, 1, 2, 0, 0, ST_IF,   0,      0,            0, 0));
        // add: IF ID EXEC WB; PCSrc=3 in ID must not touch pc; mem_ready ignored outside IF/MEM
        tbl.push_back(mk(0, 1, I_ADD,  32'h4,        0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_ADD,  32'h4,        0, 0));
        tbl.push_back(mk(0, 0, 0,      0,            0, 0,     32'hDEADBEE0, 0, 0, 3, 0, 0, ST_EXEC, I_ADD,  32'h4,        0, 0));
        tbl.push_back(mk(0, 0, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_WB,   I_ADD,  32'h4,        0, 0));
        tbl.push_back(mk(0, 0, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_IF,   I_ADD,  32'h4,        0, 1));
        // beq taken -> pc = alu_out_reg
        tbl.push_back(mk(0, 1, I_BEQ,  32'h8,        0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_BEQ,  32'h8,        0, 1));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_EXEC, I_BEQ,  32'h8,        0, 1));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_MEM,  I_BEQ,  32'h8,        0, 1));
        tbl.push_back(mk(0, 1, 0,      0,            1, 0,     0,            0, 0, 2, 1, 0, ST_WB,   I_BEQ,  32'h8,        1, 1));
        tbl.push_back(mk(0, 1, 0,      0,            0, 32'h40,0,            0, 0, 0, 0, 0, ST_IF,   I_BEQ,  32'h40,       0, 2));
        // bne with zero=1 -> not taken, pc stays at PC+4
        tbl.push_back(mk(0, 1, I_BNE,  32'h44,       0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_BNE,  32'h44,       0, 2));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_EXEC, I_BNE,  32'h44,       0, 2));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_MEM,  I_BNE,  32'h44,       0, 2));
        tbl.push_back(mk(0, 1, 0,      0,            1, 0,     0,            0, 0, 2, 1, 1, ST_WB,   I_BNE,  32'h44,       0, 2));
        tbl.push_back(mk(0, 1, 0,      0,            0, 32'h40,0,            0, 0, 0, 0, 0, ST_IF,   I_BNE,  32'h44,       0, 3));
        // lw: IF ID EXEC MEM WB
        tbl.push_back(mk(0, 1, I_LW,   32'h48,       0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_LW,   32'h48,       0, 3));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_EXEC, I_LW,   32'h48,       0, 3));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_MEM,  I_LW,   32'h48,       0, 3));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_WB,   I_LW,   32'h48,       0, 3));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_IF,   I_LW,   32'h48,       0, 4));
        // sw: IF ID EXEC MEM
        tbl.push_back(mk(0, 1, I_SW,   32'h4C,       0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_SW,   32'h4C,       0, 4));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_EXEC, I_SW,   32'h4C,       0, 4));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_MEM,  I_SW,   32'h4C,       0, 4));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_IF,   I_SW,   32'h4C,       0, 5));
        // jr: IF ID EXEC, pc <= reg_a in EXEC
        tbl.push_back(mk(0, 1, I_JR,   32'h50,       0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_JR,   32'h50,       0, 5));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_EXEC, I_JR,   32'h50,       0, 5));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     32'h100,      0, 0, 3, 0, 0, ST_IF,   I_JR,   32'h100,      0, 6));
        // jal: IF ID EXEC WB, jump in WB
        tbl.push_back(mk(0, 1, I_JAL,  32'h104,      0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_JAL,  32'h104,      0, 6));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_EXEC, I_JAL,  32'h104,      0, 6));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_WB,   I_JAL,  32'h104,      0, 6));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 1, 0, 0, ST_IF,   I_JAL,  32'h80,       0, 7));
        // jr to 0x8000_0000, then j from pc 0x8000_0004 -> 0x8000_0040
        tbl.push_back(mk(0, 1, I_JR,   32'h84,       0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_JR,   32'h84,       0, 7));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_EXEC, I_JR,   32'h84,       0, 7));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     32'h80000000, 0, 0, 3, 0, 0, ST_IF,   I_JR,   32'h80000000, 0, 8));
        tbl.push_back(mk(0, 1, I_J,    32'h80000004, 0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_J,    32'h80000004, 0, 8));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 1, 0, 0, ST_IF,   I_J,    32'h80000040, 0, 9));
        // undefined opcode and undefined funct: IF ID IF, still retired
        tbl.push_back(mk(0, 1, I_BAD,  32'h80000044, 0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_BAD,  32'h80000044, 0, 9));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_IF,   I_BAD,  32'h80000044, 0, 10));
        tbl.push_back(mk(0, 1, I_BADF, 32'h80000048, 0, 0,     0,            1, 1, 2, 0, 0, ST_ID,   I_BADF, 32'h80000048, 0, 10));
        tbl.push_back(mk(0, 1, 0,      0,            0, 0,     0,            0, 0, 2, 0, 0, ST_IF,   I_BADF, 32'h80000048, 0, 11));

        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

        // IF stall: three cycles without mem_ready hold everything, 4th completes
        repeat (3)
            cyc(mk(0, 0, I_ADD, 32'h8000004C, 0, 0, 0, 1, 1, 2, 0, 0, ST_IF, I_BADF, 32'h80000048, 0, 11));
        cyc(mk(0, 1, I_ADD, 32'h8000004C, 0, 0, 0, 1, 1, 2, 0, 0, ST_ID,   I_ADD, 32'h8000004C, 0, 11));
        cyc(mk(0, 1, 0,     0,            0, 0, 0, 0, 0, 2, 0, 0, ST_EXEC, I_ADD, 32'h8000004C, 0, 11));
        cyc(mk(0, 1, 0,     0,            0, 0, 0, 0, 0, 2, 0, 0, ST_WB,   I_ADD, 32'h8000004C, 0, 11));
        cyc(mk(0, 1, 0,     0,            0, 0, 0, 0, 0, 2, 0, 0, ST_IF,   I_ADD, 32'h8000004C, 0, 12));

        // MEM stall on beq: branch_taken must not latch until mem_ready
        cyc(mk(0, 1, I_BEQ, 32'h80000050, 0, 0, 0, 1, 1, 2, 0, 0, ST_ID,   I_BEQ, 32'h80000050, 0, 12));
        cyc(mk(0, 1, 0,     0,            0, 0, 0, 0, 0, 2, 0, 0, ST_EXEC, I_BEQ, 32'h80000050, 0, 12));
        cyc(mk(0, 1, 0,     0,            0, 0, 0, 0, 0, 2, 0, 0, ST_MEM,  I_BEQ, 32'h80000050, 0, 12));
        repeat (2)
            cyc(mk(0, 0, 0, 0,            1, 0, 0, 0, 0, 2, 1, 0, ST_MEM,  I_BEQ, 32'h80000050, 0, 12));
        cyc(mk(0, 1, 0,     0,            1, 0, 0, 0, 0, 2, 1, 0, ST_WB,   I_BEQ, 32'h80000050, 1, 12));
        cyc(mk(0, 1, 0,     0,        0, 32'h200, 0, 0, 0, 0, 0, 0, ST_IF,   I_BEQ, 32'h200,      0, 13));

        // reset during a stalled MEM: reset wins, nothing written
        cyc(mk(0, 1, I_LW,  32'h204,      0, 0, 0, 1, 1, 2, 0, 0, ST_ID,   I_LW,  32'h204,      0, 13));
        cyc(mk(0, 1, 0,     0,            0, 0, 0, 0, 0, 2, 0, 0, ST_EXEC, I_LW,  32'h204,      0, 13));
        cyc(mk(0, 1, 0,     0,            0, 0, 0, 0, 0, 2, 0, 0, ST_MEM,  I_LW,  32'h204,      0, 13));
        cyc(mk(1, 0, I_SW,  32'h999,      1, 0, 0, 1, 1, 1, 1, 0, ST_IF,   0,     0,            0, 0));
        // reset while in ID with a jump requested
        cyc(mk(0, 1, I_J,   32'h4,        0, 0, 0, 1, 1, 2, 0, 0, ST_ID,   I_J,   32'h4,        0, 0));
        cyc(mk(1, 1, 0,     0,            0, 0, 0, 0, 0, 1, 0, 0, ST_IF,   0,     0,            0, 0));

        // next-state function: undefined state codes recover to IF
        ns_opcode = OP_LW;
        for (int s = 5; s < 64; s += 9) begin
            ns_state = 6'(s);
            #1;
            chk("ns_bad_state", 32'(ns_next), 32'(ST_IF));
        end
        ns_state = ST_EXEC;
        #1;
        chk("ns_lw_exec", 32'(ns_next), 32'(ST_MEM));
        ns_opcode = OP_RTYPE; ns_funct = FN_JR;
        #1;
        chk("ns_jr_exec", 32'(ns_next), 32'(ST_IF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
